// File: rtl/nanov_spi_mem_ctrl.sv
// nanov_spi_mem_ctrl
//   SPI (mode 0) serial-memory read/write controller with read streaming.
//   A request sends an 8-bit command (0x02 write / 0x03 read), an address
//   and 1..MAX_BYTES data bytes, MSB first. After a read, chip select stays
//   low for STREAM_TIMEOUT cycles, so that a read of the next sequential
//   address can skip the command and address bits.
//
// Ports
//   clk          : clock; all logic runs on its rising edge
//   rstn         : synchronous active-low reset
//   start        : request strobe, sampled only while not busy
//   write        : 1 = write, 0 = read
//   addr         : byte address
//   len          : byte count minus one; clamped to MAX_BYTES
//   wdata        : write bytes, byte 0 = wdata[7:0]
//   rdata        : read bytes, byte 0 = rdata[7:0]; held until the next read completes
//   busy         : transfer in progress
//   done         : one-cycle completion pulse
//   spi_select   : chip select, active-low
//   spi_clk      : SPI clock
//   spi_out      : MOSI
//   spi_data_in  : MISO
module nanov_spi_mem_ctrl #(
    parameter int ADDR_BITS      = 24,
    parameter int MAX_BYTES      = 4,
    parameter int STREAM_TIMEOUT = 16,
    localparam int LEN_BITS      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   write,
    input  logic [ADDR_BITS-1:0]   addr,
    input  logic [LEN_BITS-1:0]    len,
    input  logic [8*MAX_BYTES-1:0] wdata,
    output logic [8*MAX_BYTES-1:0] rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   spi_select,
    output logic                   spi_clk,
    output logic                   spi_out,
    input  logic                   spi_data_in
);

    localparam int DW  = 8 * MAX_BYTES;
    localparam int TXW = 8 + ADDR_BITS + DW;
    localparam int CW  = 7;
    localparam int TMW = $clog2(STREAM_TIMEOUT + 1) + 1;
    localparam logic [TMW-1:0] TMO_LAST = TMW'(STREAM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_STREAM,
        S_DESELECT
    } state_t;

    state_t                 state, state_next;
    logic                   phase;      // 0 = low half of a bit, 1 = high half
    logic                   tail;       // trailing spi_clk-low cycle after the last data bit
    logic                   pending;    // request accepted outside IDLE, relaunch after deselect
    logic                   busy_r;
    logic                   done_r;
    logic [CW-1:0]          cnt;
    logic [TXW-1:0]         tx;
    logic [DW-1:0]          rx;
    logic [DW-1:0]          rdata_r;
    logic [ADDR_BITS-1:0]   next_addr;
    logic [TMW-1:0]         tmo;

    logic                   req_write;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [3:0]             req_n;
    logic [DW-1:0]          req_wdata;

    logic [3:0]             n_in;
    logic                   accept;
    logic                   stream_hit;
    logic                   shifting;

    function automatic logic [3:0] calc_n(input logic [LEN_BITS-1:0] l);
        logic [3:0] n;
        n = 4'(l) + 4'd1;
        if (n > 4'(MAX_BYTES)) n = 4'(MAX_BYTES);
        return n;
    endfunction

    // Byte 0 must go out first, so it is placed at the top of the shifter.
    function automatic logic [DW-1:0] order_tx(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++)
            r[8*(MAX_BYTES-1-i) +: 8] = w[8*i +: 8];
        return r;
    endfunction

    // The first received byte sits highest among the n received bytes.
    function automatic logic [DW-1:0] order_rx(input logic [DW-1:0] s, input logic [3:0] n);
        logic [DW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++)
            if (i < 32'(n))
                r[8*i +: 8] = s[8*(32'(n)-1-i) +: 8];
        return r;
    endfunction

    assign n_in       = calc_n(len);
    assign stream_hit = !write && (addr == next_addr);
    assign accept     = start && !busy_r &&
                        (state == S_IDLE || state == S_STREAM || state == S_DESELECT);

    assign rdata = rdata_r;
    assign busy  = busy_r;
    assign done  = done_r;

    always_ff @(posedge clk) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        shifting   = 1'b0;
        case (state)
            S_IDLE:     if (start || pending) state_next = S_SELECT;
            S_SELECT:   state_next = S_CMD;
            S_CMD: begin
                shifting = 1'b1;
                if (phase && cnt == CW'(1)) state_next = S_ADDR;
            end
            S_ADDR: begin
                shifting = 1'b1;
                if (phase && cnt == CW'(1)) state_next = S_DATA;
            end
            S_DATA: begin
                shifting = !tail;
                if (tail)
                    state_next = (req_write || STREAM_TIMEOUT == 0) ? S_DESELECT : S_STREAM;
            end
            S_STREAM: begin
                if (start)                state_next = stream_hit ? S_DATA : S_DESELECT;
                else if (tmo == TMO_LAST) state_next = S_DESELECT;
            end
            S_DESELECT: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
        spi_select = (state == S_IDLE) || (state == S_DESELECT);
        spi_clk    = shifting && phase;
        spi_out    = shifting && tx[TXW-1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_write <= 1'b0;
            req_addr  <= '0;
            req_n     <= '0;
            req_wdata <= '0;
        end else if (accept) begin
            req_write <= write;
            req_addr  <= addr;
            req_n     <= n_in;
            req_wdata <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase     <= 1'b0;
            tail      <= 1'b0;
            pending   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cnt       <= '0;
            tx        <= '0;
            rx        <= '0;
            rdata_r   <= '0;
            next_addr <= '0;
            tmo       <= '0;
        end else begin
            done_r <= 1'b0;
            if (accept) busy_r <= 1'b1;
            case (state)
                S_IDLE: begin
                    phase <= 1'b0;
                    if (pending) pending <= 1'b0;
                end
                S_SELECT: begin
                    tx    <= {(req_write ? 8'h02 : 8'h03), req_addr,
                              (req_write ? order_tx(req_wdata) : DW'(0))};
                    cnt   <= CW'(8);
                    phase <= 1'b0;
                    tail  <= 1'b0;
                end
                S_CMD, S_ADDR: begin
                    phase <= ~phase;
                    if (phase) begin
                        tx <= tx << 1;
                        if (cnt == CW'(1))
                            cnt <= (state == S_CMD) ? CW'(ADDR_BITS) : {req_n, 3'b000};
                        else
                            cnt <= cnt - CW'(1);
                    end
                end
                S_DATA: begin
                    if (tail) begin
                        tail   <= 1'b0;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        tmo    <= '0;
                        if (!req_write) begin
                            rdata_r   <= order_rx(rx, req_n);
                            next_addr <= req_addr + ADDR_BITS'(req_n);
                        end
                    end else begin
                        phase <= ~phase;
                        if (phase) begin
                            tx  <= tx << 1;
                            rx  <= {rx[DW-2:0], spi_data_in};
                            cnt <= cnt - CW'(1);
                            if (cnt == CW'(1)) tail <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (start) begin
                        if (stream_hit) begin
                            // Sequential read: select is still low, go straight to data bits.
                            tx    <= '0;
                            cnt   <= {n_in, 3'b000};
                            phase <= 1'b0;
                            tail  <= 1'b0;
                        end else begin
                            pending <= 1'b1;
                        end
                    end else begin
                        tmo <= tmo + TMW'(1);
                    end
                end
                S_DESELECT: begin
                    if (accept) pending <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nanov_spi_mem_ctrl.sv
module tb_nanov_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        write = 1'b0;
    logic [23:0] addr = '0;
    logic [1:0]  len = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        busy, done, spi_select, spi_clk, spi_out, spi_data_in;

    nanov_spi_mem_ctrl #(
        .ADDR_BITS(24),
        .MAX_BYTES(4),
        .STREAM_TIMEOUT(16)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .write(write),
        .addr(addr),
        .len(len),
        .wdata(wdata),
        .rdata(rdata),
        .busy(busy),
        .done(done),
        .spi_select(spi_select),
        .spi_clk(spi_clk),
        .spi_out(spi_out),
        .spi_data_in(spi_data_in)
    );

    always #5 clk = ~clk;

    // SPI memory model: counts bits at the clk edge ending each high phase,
    // logs MOSI, and presents response bits once the data phase starts.
    int           bitn = 0;
    logic [127:0] mosi_log = '0;
    int           data_base = 0;
    logic [31:0]  resp = '0;
    int           miso_idx;

    always @(posedge clk) begin
        if (spi_clk) begin
            bitn     <= bitn + 1;
            mosi_log <= {mosi_log[126:0], spi_out};
        end
    end

    always_comb begin
        miso_idx    = bitn - data_base;
        spi_data_in = (miso_idx >= 0 && miso_idx < 32) ? resp[31 - miso_idx] : 1'b0;
    end

    int checks = 0;
    int errors = 0;
    int b0 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic w, input logic [23:0] a, input logic [1:0] l,
                          input logic [31:0] wd, input logic [31:0] r, input int skip);
        @(negedge clk);
        write     = w;
        addr      = a;
        len       = l;
        wdata     = wd;
        resp      = r;
        b0        = bitn;
        data_base = bitn + skip;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!done && k < limit);
    endtask

    int k;
    int seen;

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_select", spi_select, 1'b1);
        chk("rst_spi_clk", spi_clk, 1'b0);
        chk("rst_spi_out", spi_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // full read of 4 bytes
        launch(1'b0, 24'h000100, 2'd3, 32'h0, 32'h11223344, 32);
        chk("rd1_busy", busy, 1'b1);
        chk("rd1_select", spi_select, 1'b0);
        wait_done(300, k);
        chk("rd1_latency", k, 130);
        chk("rd1_rdata", rdata, 32'h44332211);
        chk("rd1_bits", bitn - b0, 64);
        chk("rd1_mosi_hdr", mosi_log[63:32], 32'h03000100);
        chk("rd1_busy_at_done", busy, 1'b0);
        chk("rd1_stream_select", spi_select, 1'b0);
        @(posedge clk);
        #1;
        chk("rd1_done_pulse", done, 1'b0);

        // streamed sequential read
        launch(1'b0, 24'h000104, 2'd3, 32'h0, 32'h55667788, 0);
        chk("st1_busy", busy, 1'b1);
        wait_done(300, k);
        chk("st1_latency", k, 65);
        chk("st1_bits", bitn - b0, 32);
        chk("st1_rdata", rdata, 32'h88776655);

        // stream timeout, then a full read of next_addr
        repeat (15) @(posedge clk);
        #1;
        chk("tmo_select_15", spi_select, 1'b0);
        @(posedge clk);
        #1;
        chk("tmo_select_16", spi_select, 1'b1);
        @(posedge clk);
        #1;
        chk("tmo_idle_select", spi_select, 1'b1);
        chk("tmo_idle_busy", busy, 1'b0);
        launch(1'b0, 24'h000108, 2'd3, 32'h0, 32'h99AABBCC, 32);
        wait_done(300, k);
        chk("rd2_latency", k, 130);
        chk("rd2_mosi_hdr", mosi_log[63:32], 32'h03000108);
        chk("rd2_rdata", rdata, 32'hCCBBAA99);

        // non-sequential start while streaming: deselect and full 1-byte read
        launch(1'b0, 24'h000300, 2'd0, 32'h0, 32'h5A000000, 32);
        chk("ns_deselect", spi_select, 1'b1);
        chk("ns_busy", busy, 1'b1);
        wait_done(300, k);
        chk("ns_latency", k, 84);
        chk("ns_bits", bitn - b0, 40);
        chk("ns_mosi_hdr", mosi_log[39:8], 32'h03000300);
        chk("ns_rdata_zero_fill", rdata, 32'h0000005A);

        // write from IDLE
        repeat (20) @(posedge clk);
        launch(1'b1, 24'h000200, 2'd1, 32'h0000BEEF, 32'hFFFFFFFF, 32);
        wait_done(300, k);
        chk("wr_latency", k, 98);
        chk("wr_mosi", mosi_log[47:0], 48'h02000200EFBE);
        chk("wr_rdata_kept", rdata, 32'h0000005A);
        chk("wr_select_done", spi_select, 1'b1);
        @(posedge clk);
        #1;
        chk("wr_select_after", spi_select, 1'b1);
        chk("wr_spi_clk", spi_clk, 1'b0);

        // address wrap, with a start pulse ignored while busy
        repeat (2) @(posedge clk);
        launch(1'b0, 24'hFFFFFC, 2'd3, 32'h0, 32'h01020304, 32);
        repeat (9) @(posedge clk);
        @(negedge clk);
        write = 1'b1;
        addr  = 24'h000000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(300, k);
        chk("wrap_rd_latency", k + 10, 130);
        chk("wrap_rd_rdata", rdata, 32'h04030201);
        launch(1'b0, 24'h000000, 2'd3, 32'h0, 32'h05060708, 0);
        wait_done(300, k);
        chk("wrap_st_latency", k, 65);
        chk("wrap_st_bits", bitn - b0, 32);
        chk("wrap_st_rdata", rdata, 32'h08070605);

        // reset in the middle of a read
        repeat (20) @(posedge clk);
        launch(1'b0, 24'h000100, 2'd3, 32'h0, 32'h11223344, 32);
        repeat (39) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_select", spi_select, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_done", done, 1'b0);
        chk("abort_spi_clk", spi_clk, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_idle_select", spi_select, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
